// File: rtl/kbd_hex_display_if.sv
// kbd_hex_display_if: scancode strobe in, multiplexed display and status out
interface kbd_hex_display_if;
  logic [7:0] scancode;
  logic       valid;
  logic [3:0] an;
  logic [6:0] seg;
  logic [2:0] count;
  logic       err;
  modport master(output scancode, valid, input an, seg, count, err);
  modport slave(input scancode, valid, output an, seg, count, err);
endinterface

// File: rtl/kbd_hex_display.sv
// kbd_hex_display: 4-char hex key history shown on a multiplexed 7-segment display
module kbd_hex_display #(
  parameter int CNT_WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  kbd_hex_display_if.slave bus
);
  logic [CNT_WIDTH-1:0] refresh;
  logic [1:0] sel;
  logic [3:0] occ;
  logic [3:0] nib [4];
  logic [2:0] count_q;
  logic       err_q;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       is_hex, is_bs, is_clr, unknown;
  logic [3:0] code_nib;
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
  always_comb begin
    is_hex   = 1'b1;
    is_bs    = 1'b0;
    is_clr   = 1'b0;
    code_nib = 4'h0;
    case (bus.scancode)
      8'h45: code_nib = 4'h0;
      8'h16: code_nib = 4'h1;
      8'h1E: code_nib = 4'h2;
      8'h26: code_nib = 4'h3;
      8'h25: code_nib = 4'h4;
      8'h2E: code_nib = 4'h5;
      8'h36: code_nib = 4'h6;
      8'h3D: code_nib = 4'h7;
      8'h3E: code_nib = 4'h8;
      8'h46: code_nib = 4'h9;
      8'h1C: code_nib = 4'hA;
      8'h32: code_nib = 4'hB;
      8'h21: code_nib = 4'hC;
      8'h23: code_nib = 4'hD;
      8'h24: code_nib = 4'hE;
      8'h2B: code_nib = 4'hF;
      8'h66: begin
        is_hex = 1'b0;
        is_bs  = 1'b1;
      end
      8'h76: begin
        is_hex = 1'b0;
        is_clr = 1'b1;
      end
      default: is_hex = 1'b0;
    endcase
    unknown = !is_hex && !is_bs && !is_clr;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh <= '0;
      sel     <= 2'd0;
      occ     <= 4'h0;
      nib     <= '{default: 4'h0};
      count_q <= 3'd0;
      err_q   <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
    end else begin
      refresh <= refresh + 1'b1;
      if (&refresh) sel <= sel + 2'd1;
      err_q <= bus.valid && unknown;
      if (bus.valid && is_hex) begin
        occ     <= {occ[2:0], 1'b1};
        nib[3]  <= nib[2];
        nib[2]  <= nib[1];
        nib[1]  <= nib[0];
        nib[0]  <= code_nib;
        count_q <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
      end else if (bus.valid && is_bs && count_q != 3'd0) begin
        occ     <= {1'b0, occ[3:1]};
        nib[0]  <= nib[1];
        nib[1]  <= nib[2];
        nib[2]  <= nib[3];
        count_q <= count_q - 3'd1;
      end else if (bus.valid && is_clr) begin
        occ     <= 4'h0;
        count_q <= 3'd0;
      end
      // outputs lag the select/buffer by one register stage
      an_q  <= ~(4'b0001 << sel);
      seg_q <= occ[sel] ? font(nib[sel]) : 7'h7F;
    end
  end
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.count = count_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_kbd_hex_display.sv
// tb_kbd_hex_display: scoreboard bench for the hex key history display
module tb_kbd_hex_display;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  kbd_hex_display_if bus();
  kbd_hex_display #(.CNT_WIDTH(2)) dut(.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  typedef struct packed {logic [2:0] cnt; logic err;} exp_t;
  exp_t sb[$];
  logic [3:0] m_nib [4];
  logic [3:0] m_occ;
  int m_cnt;
  logic [6:0] font_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int dec(input logic [7:0] c);
    case (c)
      8'h45: return 0;
      8'h16: return 1;
      8'h1E: return 2;
      8'h26: return 3;
      8'h25: return 4;
      8'h2E: return 5;
      8'h36: return 6;
      8'h3D: return 7;
      8'h3E: return 8;
      8'h46: return 9;
      8'h1C: return 10;
      8'h32: return 11;
      8'h21: return 12;
      8'h23: return 13;
      8'h24: return 14;
      8'h2B: return 15;
      8'h66: return 16;
      8'h76: return 17;
      default: return -1;
    endcase
  endfunction
  // drive one key at a negedge, predict, then compare at the next negedge
  task automatic key(input logic [7:0] c);
    int d;
    logic e;
    exp_t x;
    d = dec(c);
    e = 1'b0;
    bus.scancode = c;
    bus.valid = 1'b1;
    if (d >= 0 && d < 16) begin
      for (int i = 3; i > 0; i--) m_nib[i] = m_nib[i-1];
      m_nib[0] = d[3:0];
      m_occ = {m_occ[2:0], 1'b1};
      if (m_cnt < 4) m_cnt++;
    end else if (d == 16) begin
      if (m_cnt > 0) begin
        for (int i = 0; i < 3; i++) m_nib[i] = m_nib[i+1];
        m_occ = {1'b0, m_occ[3:1]};
        m_cnt--;
      end
    end else if (d == 17) begin
      m_occ = 4'h0;
      m_cnt = 0;
    end else e = 1'b1;
    sb.push_back(exp_t'{3'(m_cnt), e});
    @(negedge clk);
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      x = sb.pop_front();
      chk($sformatf("count_%02h", c), 32'(bus.count), 32'(x.cnt));
      chk($sformatf("err_%02h", c), 32'(bus.err), 32'(x.err));
    end
  endtask
  task automatic check_digits();
    logic [3:0] ea;
    logic [6:0] es;
    int w;
    bus.valid = 1'b0;
    @(negedge clk);
    chk("count_idle", 32'(bus.count), 32'(m_cnt));
    for (int d = 0; d < 4; d++) begin
      ea = ~(4'b0001 << d);
      w = 0;
      while (bus.an !== ea && w < 40) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("an_wait%0d", d), 32'(w < 40), 1);
      es = m_occ[d] ? font_t[m_nib[d]] : 7'h7F;
      chk($sformatf("seg%0d", d), 32'(bus.seg), 32'(es));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.valid = 1'b0;
    bus.scancode = 8'h00;
    m_occ = 4'h0;
    m_cnt = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_err", 32'(bus.err), 0);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("scan_an%0d", k), 32'(bus.an), 32'(4'(~(4'b0001 << (((k - 1) / 4) % 4)))));
      chk($sformatf("scan_seg%0d", k), 32'(bus.seg), 32'h7F);
    end
    key(8'h16); key(8'h1E); key(8'h26);
    check_digits();
    key(8'h25); key(8'h2B);
    check_digits();
    key(8'h66); key(8'h66);
    check_digits();
    repeat (5) key(8'h66);
    check_digits();
    key(8'h3E);
    key(8'h5A);
    bus.valid = 1'b0;
    @(negedge clk);
    chk("err_one_cycle", 32'(bus.err), 0);
    check_digits();
    key(8'h76);
    check_digits();
    key(8'h45); key(8'h45);
    bus.scancode = 8'h1C;
    bus.valid = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    m_occ = 4'h0;
    m_cnt = 0;
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_an", 32'(bus.an), 32'hF);
    chk("midrst_seg", 32'(bus.seg), 32'h7F);
    chk("midrst_err", 32'(bus.err), 0);
    bus.valid = 1'b0;
    reset = 1'b1;
    check_digits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kbd_hex_display.md
Name: kbd_hex_display

Overview:
- Downstream consumer of the PS/2 keyboard protocol stage.
- Takes the registered key-release `scancode` and its one-cycle `valid` pulse.
- Decodes hex keys (0-9, A-F) and keeps a 4-character history, newest on the right.
- Time-multiplexes the history onto a 4-digit common-anode 7-segment display. Also supports backspace and clear keys.

Parameters:
- CNT_WIDTH, 16, width of the free-running refresh counter. The digit advances each time the counter wraps. Use 2-4 in simulation.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- scancode  input  8  set-2 scancode of a released key, valid only while `valid`=1
- valid  input  1  one-cycle strobe; back-to-back pulses allowed
- an  output  4  digit anodes, active-low; an[i] drives digit i, digit 0 rightmost
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- count  output  3  number of stored characters, 0..4
- err  output  1  one-cycle pulse on an unrecognised scancode

Behaviour:
- Reset:
  - Applied on a clk edge with reset=0; takes precedence over `valid`.
  - Sets all entries empty, count=0, err=0, refresh counter=0, digit select=0, an=4'b1111, seg=7'h7F.
  - Reset mid-operation discards the history immediately.
- Storage:
  - 4 entries e0..e3, each a 1-bit occupied flag plus a 4-bit nibble.
  - e0 is the newest entry and maps to digit 0.
- Decode, applied only on edges where valid=1 (all values hex):
  - 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9
  - 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F
  - 66=backspace, 76=clear; anything else is unknown.
- Hex key:
  - Shift e3<=e2, e2<=e1, e1<=e0, e0<={1,nibble}.
  - count<=min(count+1,4). At count=4 the old e3 is lost.
- Backspace:
  - With count>0: e0<=e1, e1<=e2, e2<=e3, e3<=empty, count<=count-1.
  - With count=0: no change, no err.
- Clear: all entries empty, count<=0.
- Unknown code: buffer unchanged; err=1 for exactly the next cycle.
- Timing:
  - Buffer, count and err update on the edge that samples valid=1, so they are visible the following cycle.
  - With valid=0, err=0 and the buffer holds.
- Refresh:
  - The counter increments every cycle and wraps to 0.
  - On the edge where the counter is all-ones, the 2-bit digit select increments, wrapping 3->0.
- Display outputs:
  - an and seg are registered from the current digit select and entry.
  - an = ~(4'b0001 << sel).
  - seg = font(nibble) if entry sel is occupied, else 7'h7F (blank).
  - Latency is one cycle from a select change or buffer update to the outputs.
- Font (hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Guaranteed invariants:
  - Exactly one an bit is low at all times after the first post-reset cycle.
  - count never exceeds 4.
  - Occupied entries are always contiguous from e0.

Test Plan:
1. Reset, then hold reset=1 with no keys (CNT_WIDTH=2) -> count=0, err=0, seg=7F on all digits; an cycles 1110, 1101, 1011, 0111 every 4 cycles.
2. Pulse valid with 16, 1E, 26 -> count=3; e0=3, e1=2, e2=1. Digit 0 shows seg=30, digit 1 shows 24, digit 2 shows 79, digit 3 shows 7F.
3. From step 2, send 25 then 2B -> count=4; digits 3..0 show 2,3,4,F (24, 30, 19, 0E). Nibble 1 is discarded.
4. From step 3, send 66 twice -> count=2; digit 0 shows 3 (30), digit 1 shows 2 (24), digits 2-3 show 7F. Then on an empty buffer, send 66 five times -> count=0, err stays 0.
5. Send 5A (Enter) -> err=1 for exactly one cycle, buffer unchanged. Then send 76 -> count=0, all digits 7F.
6. Send 45 on back-to-back cycles, then assert reset=0 on the cycle of a third valid pulse (1C) -> after reset, count=0, an=1111, seg=7F. The 1C is not stored.
